// File: rtl/shift_rows.sv
// shift_rows: AES-128 ShiftRows stage, registered with one cycle of latency.
//
// Sits between SubBytes and MixColumns. Row r of the 4x4 byte state is rotated
// left by r positions. A new state is accepted on every clock edge; there is
// no stall.
//
// Byte i of a 128-bit state lives at [127-8*i -: 8] (byte 0 is the MSB).
// Bytes are column-major: i = row + 4*col.
//
// Optional feature macro: SHIFT_ROWS_INV_EN
//   When defined, an extra input 'inv' selects InvShiftRows (row r rotated
//   right by r). Latency and reset behaviour are the same as the forward path.
//
// Ports:
//   clk            in   1    clock, rising edge
//   rst            in   1    synchronous, active-high reset
//   inv            in   1    (SHIFT_ROWS_INV_EN only) 1 = inverse map
//   state          in   128  input AES state
//   shifted_state  out  128  registered ShiftRows result
//   out_valid      out  1    shifted_state holds a result from a post-reset input
module shift_rows #(
    parameter logic [127:0] RESET_VALUE = 128'h0
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SHIFT_ROWS_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] state,
    output logic [127:0] shifted_state,
    output logic         out_valid
);

    logic [127:0] shifted_state_d, shifted_state_q;
    logic         out_valid_d, out_valid_q;
    logic [127:0] fwd_map;
`ifdef SHIFT_ROWS_INV_EN
    logic [127:0] inv_map;
`endif

    // Pure wiring: each output byte is copied from its permuted source byte.
    always_comb begin
        fwd_map = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                fwd_map[127 - 8 * (r + 4 * c) -: 8] =
                    state[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    always_comb begin
        inv_map = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                // +4 keeps the modulo operand non-negative.
                inv_map[127 - 8 * (r + 4 * c) -: 8] =
                    state[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
    end
`endif

    always_comb begin
`ifdef SHIFT_ROWS_INV_EN
        shifted_state_d = inv ? inv_map : fwd_map;
`else
        shifted_state_d = fwd_map;
`endif
        out_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifted_state_q <= RESET_VALUE;
            out_valid_q     <= 1'b0;
        end else begin
            shifted_state_q <= shifted_state_d;
            out_valid_q     <= out_valid_d;
        end
    end

    assign shifted_state = shifted_state_q;
    assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_shift_rows.sv
// tb_shift_rows: directed-vector bench for shift_rows.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. just after the edge that registered them.
module tb_shift_rows;

    logic         clk;
    logic         rst;
    logic [127:0] state;
    logic [127:0] shifted_state;
    logic         out_valid;
`ifdef SHIFT_ROWS_INV_EN
    logic         inv;
`endif

    int n_checks = 0;
    int n_errors = 0;

    shift_rows #(
        .RESET_VALUE(128'h0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SHIFT_ROWS_INV_EN
        .inv          (inv),
`endif
        .state        (state),
        .shifted_state(shifted_state),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed vectors and their ShiftRows results.
    localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1 = 128'h0055aaff4499ee3388dd2277cc1166bb;
    localparam logic [127:0] V2 = 128'hd4e0b81e27bfb44111985d52aef1e530;
    localparam logic [127:0] R2 = 128'hd4bf5d302798e51e11f1b841aee0b452;
    localparam logic [127:0] V3 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R3 = 128'h00050a0f04090e03080d02070c01060b;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        state = V1;
`ifdef SHIFT_ROWS_INV_EN
        inv   = 1'b0;
`endif
        tick();
        tick();
        check_eq("reset_state", shifted_state, 128'h0);
        check_eq("reset_valid", {127'b0, out_valid}, 128'h0);

        // Single vector, then a back-to-back stream.
        rst   = 1'b0;
        state = V1;
        tick();
        check_eq("v1_state", shifted_state, R1);
        check_eq("v1_valid", {127'b0, out_valid}, 128'h1);
        state = V2;
        tick();
        check_eq("v2_state", shifted_state, R2);
        check_eq("v2_valid", {127'b0, out_valid}, 128'h1);
        state = V3;
        tick();
        check_eq("v3_state", shifted_state, R3);
        state = V1;
        tick();
        check_eq("b2b_v1", shifted_state, R1);
        state = V2;
        tick();
        check_eq("b2b_v2", shifted_state, R2);

        // Reset mid-stream: the applied vector is lost.
        state = V3;
        rst   = 1'b1;
        tick();
        check_eq("midrst_state", shifted_state, 128'h0);
        check_eq("midrst_valid", {127'b0, out_valid}, 128'h0);

        // First edge after reset falls captures the current input.
        rst   = 1'b0;
        state = V2;
        tick();
        check_eq("postrst_state", shifted_state, R2);
        check_eq("postrst_valid", {127'b0, out_valid}, 128'h1);

`ifdef SHIFT_ROWS_INV_EN
        inv   = 1'b1;
        state = R1;
        tick();
        check_eq("inv_r1", shifted_state, V1);
        state = R3;
        tick();
        check_eq("inv_r3", shifted_state, V3);
        inv   = 1'b0;
        state = V3;
        tick();
        check_eq("inv_off_v3", shifted_state, R3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
